// File: rtl/sram_1r1w_fwd_pkg.sv
// Shared helpers for the 1R1W flop-based memory.
package sram_1r1w_fwd_pkg;

   // True when an address selects a real entry of a SIZE-entry array.
   function automatic logic in_range(input int unsigned addr, input int unsigned size);
      return addr < size;
   endfunction

endpackage : sram_1r1w_fwd_pkg

// File: rtl/sram_1r1w_fwd.sv
// Single-clock 1R1W memory built from flops. One synchronous write port and
// one registered read port (1-cycle latency); an optional same-cycle
// write-to-read forwarding path is selected at elaboration time.
module sram_1r1w_fwd
   import sram_1r1w_fwd_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SIZE       = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int FORWARDING = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rd_enable,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_enable,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [DATA_WIDTH-1:0] mem [SIZE];
   logic                  wr_ok;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] rd_array;
   logic [DATA_WIDTH-1:0] rd_next;

   // Out-of-range addresses never touch the array: writes drop, reads yield 0.
   assign wr_ok = wr_enable && in_range(32'(wr_addr), 32'(SIZE));
   assign rd_ok = in_range(32'(rd_addr), 32'(SIZE));

   // Storage array: cleared by reset, written on accepted writes.
   // NOTE: this array is plain flops used for LRU/tag state that must start
   // known, so it is reset like any other register; a real SRAM macro would not be.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SIZE; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         // NOTE: non-blocking assignment, so a read on this same edge still
         // samples the pre-write contents of the array.
         mem[wr_addr] <= wr_data;
      end
   end

   // Array lookup for the read address; zero when the address is out of range.
   always_comb begin
      // NOTE: default first so no path leaves rd_array unassigned (no latch).
      rd_array = '0;
      if (rd_ok) begin
         rd_array = mem[rd_addr];
      end
   end

   // Forwarding mux exists only when FORWARDING is set; otherwise the read
   // returns the old contents and no address comparator is built.
   generate
      if (FORWARDING != 0) begin : g_fwd
         assign rd_next = (wr_ok && (wr_addr == rd_addr)) ? wr_data : rd_array;
      end else begin : g_no_fwd
         assign rd_next = rd_array;
      end
   endgenerate

   // Read result register: loads on rd_enable, otherwise holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_enable) begin
         rd_data <= rd_next;
      end
   end

endmodule : sram_1r1w_fwd

// File: tb/tb_sram_1r1w_fwd.sv
// Self-checking bench for sram_1r1w_fwd. Three instances share one stimulus
// stream: FORWARDING=1/SIZE=32, FORWARDING=0/SIZE=32, FORWARDING=1/SIZE=30.
module tb_sram_1r1w_fwd;

   localparam int DW = 3;
   localparam int AW = 5;
   localparam int NCFG = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rd_enable;
   logic [AW-1:0] rd_addr;
   logic          wr_enable;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_fwd, rd_nofwd, rd_s30;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_1r1w_fwd #(.DATA_WIDTH(DW), .SIZE(32), .ADDR_WIDTH(AW), .FORWARDING(1)) u_fwd (
      .clk(clk), .reset_n(reset_n), .rd_enable(rd_enable), .rd_addr(rd_addr),
      .rd_data(rd_fwd), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data));

   sram_1r1w_fwd #(.DATA_WIDTH(DW), .SIZE(32), .ADDR_WIDTH(AW), .FORWARDING(0)) u_nofwd (
      .clk(clk), .reset_n(reset_n), .rd_enable(rd_enable), .rd_addr(rd_addr),
      .rd_data(rd_nofwd), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data));

   sram_1r1w_fwd #(.DATA_WIDTH(DW), .SIZE(30), .ADDR_WIDTH(AW), .FORWARDING(1)) u_s30 (
      .clk(clk), .reset_n(reset_n), .rd_enable(rd_enable), .rd_addr(rd_addr),
      .rd_data(rd_s30), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data));

   // Reference model: one plain array and expected read value per configuration.
   int            cfg_size [NCFG] = '{32, 32, 30};
   bit            cfg_fwd  [NCFG] = '{1'b1, 1'b0, 1'b1};
   logic [DW-1:0] m_mem [NCFG][32];
   logic [DW-1:0] m_rd  [NCFG];

   typedef struct {
      bit            re;
      logic [AW-1:0] ra;
      bit            we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [DW-1:0] e_fwd;
      logic [DW-1:0] e_nofwd;
      logic [DW-1:0] e_s30;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCFG; k++) begin
         m_rd[k] = '0;
         for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
      end
   endtask

   // One clock edge of the memory as the rules describe it.
   task automatic model_step(input bit re, input logic [AW-1:0] ra, input bit we,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      for (int k = 0; k < NCFG; k++) begin
         if (re) begin
            if (int'(ra) < cfg_size[k]) begin
               m_rd[k] = m_mem[k][ra];
               if (cfg_fwd[k] && we && wa == ra) m_rd[k] = wd;
            end else begin
               m_rd[k] = '0;
            end
         end
         if (we && int'(wa) < cfg_size[k]) m_mem[k][wa] = wd;
      end
   endtask

   // Drive at the falling edge, let one rising edge pass, sample 1ns later.
   task automatic drive_cycle(input bit re, input logic [AW-1:0] ra, input bit we,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      @(negedge clk);
      rd_enable = re;
      rd_addr   = ra;
      wr_enable = we;
      wr_addr   = wa;
      wr_data   = wd;
      @(posedge clk);
      #1;
      model_step(re, ra, we, wa, wd);
   endtask

   task automatic check_model(input string name);
      check({name, "/fwd"},   rd_fwd,   m_rd[0]);
      check({name, "/nofwd"}, rd_nofwd, m_rd[1]);
      check({name, "/s30"},   rd_s30,   m_rd[2]);
   endtask

   task automatic set_vec(input int i, input bit re, input int ra, input bit we, input int wa,
                          input int wd, input int ef, input int en, input int es);
      tbl[i].re      = re;
      tbl[i].ra      = AW'(ra);
      tbl[i].we      = we;
      tbl[i].wa      = AW'(wa);
      tbl[i].wd      = DW'(wd);
      tbl[i].e_fwd   = DW'(ef);
      tbl[i].e_nofwd = DW'(en);
      tbl[i].e_s30   = DW'(es);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] prev;
      logic [AW-1:0] ra, wa;

      //            re ra  we wa  wd  fwd nofwd s30
      set_vec( 0, 0,  0, 1,  7, 6,  0,  0,  0);  // write 7 <= 110
      set_vec( 1, 1,  7, 0,  0, 0,  6,  6,  6);  // read back next cycle
      set_vec( 2, 0,  0, 0,  0, 0,  6,  6,  6);  // hold x3
      set_vec( 3, 0,  0, 0,  0, 0,  6,  6,  6);
      set_vec( 4, 0,  0, 0,  0, 0,  6,  6,  6);
      set_vec( 5, 0,  0, 1,  9, 1,  6,  6,  6);  // address 9 holds 001
      set_vec( 6, 1,  9, 1,  9, 7,  7,  1,  7);  // collision: fwd vs old data
      set_vec( 7, 1,  9, 0,  0, 0,  7,  7,  7);  // write committed in all modes
      set_vec( 8, 0,  0, 1,  5, 4,  7,  7,  7);  // address 5 holds 100
      set_vec( 9, 1,  5, 1,  3, 2,  4,  4,  4);  // independent ports
      set_vec(10, 1,  3, 0,  0, 0,  2,  2,  2);
      set_vec(11, 0,  0, 1, 31, 5,  2,  2,  2);  // top address (out of range for SIZE=30)
      set_vec(12, 1, 31, 0,  0, 0,  5,  5,  0);
      set_vec(13, 1, 31, 1, 31, 3,  3,  5,  0);

      reset_n   = 1'b0;
      rd_enable = 1'b0;
      rd_addr   = '0;
      wr_enable = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset/fwd",   rd_fwd,   3'd0);
      check("reset/nofwd", rd_nofwd, 3'd0);
      check("reset/s30",   rd_s30,   3'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Table-driven directed vectors.
      for (int i = 0; i < 14; i++) begin
         drive_cycle(tbl[i].re, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd);
         check($sformatf("vec%0d/fwd", i),   rd_fwd,   tbl[i].e_fwd);
         check($sformatf("vec%0d/nofwd", i), rd_nofwd, tbl[i].e_nofwd);
         check($sformatf("vec%0d/s30", i),   rd_s30,   tbl[i].e_s30);
      end

      // Reset mid-operation: clears immediately, same-edge accesses are lost.
      drive_cycle(1'b0, 5'd0, 1'b1, 5'd4, 3'b101);
      drive_cycle(1'b1, 5'd4, 1'b0, 5'd0, 3'd0);
      check_model("pre_reset");
      rd_enable = 1'b1;
      rd_addr   = 5'd4;
      wr_enable = 1'b1;
      wr_addr   = 5'd4;
      wr_data   = 3'b011;
      reset_n   = 1'b0;
      #1;
      check("async_reset/fwd",   rd_fwd,   3'd0);
      check("async_reset/nofwd", rd_nofwd, 3'd0);
      check("async_reset/s30",   rd_s30,   3'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("reset_edge/fwd", rd_fwd, 3'd0);
      @(negedge clk);
      rd_enable = 1'b0;
      wr_enable = 1'b0;
      reset_n   = 1'b1;
      drive_cycle(1'b1, 5'd4, 1'b0, 5'd0, 3'd0);
      check("read_after_reset/fwd",   rd_fwd,   3'd0);
      check("read_after_reset/nofwd", rd_nofwd, 3'd0);
      check_model("read_after_reset");

      // Back-to-back LRU pattern: read s, write the previous cycle's address.
      prev = '0;
      for (int i = 0; i <= 40; i++) begin
         drive_cycle(1'b1, AW'(i % 32), i > 0, prev, DW'($urandom));
         check_model($sformatf("lru%0d", i));
         prev = AW'(i % 32);
      end

      // Randomized traffic with frequent same-address collisions.
      for (int i = 0; i < 400; i++) begin
         ra = AW'($urandom_range(0, 31));
         wa = ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 31));
         drive_cycle($urandom_range(0, 3) != 0, ra, $urandom_range(0, 1) == 1, wa, DW'($urandom));
         check_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_sram_1r1w_fwd
